score_keeper: RTL

SCORE_KEEPER -- requirements
Module: score_keeper

---
 rtl/score_keeper.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/score_keeper.sv
// Purpose: match scorer for a two-player paddle game. It sequences idle, the serve delay, play and
//          game over, and it declares the winner. Build option SCORE_KEEPER_SERVE_DELAY_EN enables the counted serve delay.
// Latency: a score appears 1 cycle after score_valid. serve pulses on the first PLAY cycle.
// Backpressure: none. Each pulse input is acted on or dropped in the cycle it arrives, depending on the current state.
module score_keeper #(
    parameter int WIN_SCORE   = 9,
    parameter int SERVE_DELAY = 50000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       score_valid,
    input  logic [1:0] who_scored,
    output logic [3:0] num_0,
    output logic [3:0] num_1,
    output logic [1:0] winner,
    output logic       serve,
    output logic       serve_dir,
    output logic [1:0] state
);

    typedef enum logic [1:0] {
        ST_IDLE       = 2'b00,
        ST_SERVE_WAIT = 2'b01,
        ST_PLAY       = 2'b10,
        ST_OVER       = 2'b11
    } state_t;

    localparam logic [3:0] WIN = 4'(WIN_SCORE);

    state_t     cur_state;
    state_t     nxt_state;
    logic [3:0] nxt_num_0;
    logic [3:0] nxt_num_1;
    logic [1:0] nxt_winner;
    logic       nxt_serve;
    logic       nxt_serve_dir;
    logic       clr_wait;
    logic       wait_done;
    logic [3:0] inc_0;
    logic [3:0] inc_1;

    assign inc_0 = num_0 + 4'd1;
    assign inc_1 = num_1 + 4'd1;
    assign state = cur_state;

`ifdef SCORE_KEEPER_SERVE_DELAY_EN
    localparam logic [25:0] WAIT_LAST = 26'(SERVE_DELAY - 1);

    logic [25:0] wait_cnt;

    // Serve-delay counter. It restarts from zero each time SERVE_WAIT is entered.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wait_cnt <= '0;
        end else if (clr_wait) begin
            wait_cnt <= '0;
        end else if (cur_state == ST_SERVE_WAIT) begin
            wait_cnt <= wait_cnt + 26'd1;
        end
    end

    assign wait_done = (wait_cnt == WAIT_LAST);
`else
    // No counter is built in this configuration. SERVE_WAIT always ends after a single cycle.
    // The delay parameter is only referenced here, so the parameter list stays the same in both builds.
    assign wait_done = (SERVE_DELAY > 0) || 1'b1;
`endif

    // Next-state logic. It also computes the score, winner and serve updates for the coming cycle.
    always_comb begin
        nxt_state     = cur_state;
        nxt_num_0     = num_0;
        nxt_num_1     = num_1;
        nxt_winner    = winner;
        nxt_serve     = 1'b0;
        nxt_serve_dir = serve_dir;
        clr_wait      = 1'b0;
        case (cur_state)
            ST_IDLE, ST_OVER: begin
                if (start) begin
                    nxt_state     = ST_SERVE_WAIT;
                    nxt_num_0     = 4'd0;
                    nxt_num_1     = 4'd0;
                    nxt_winner    = 2'b00;
                    nxt_serve_dir = 1'b0;
                    clr_wait      = 1'b1;
                end
            end
            ST_SERVE_WAIT: begin
                if (wait_done) begin
                    nxt_state = ST_PLAY;
                    nxt_serve = 1'b1;
                end
            end
            ST_PLAY: begin
                // start is deliberately ignored here, even when it arrives together with a point.
                if (score_valid && who_scored == 2'b01) begin
                    nxt_num_0     = inc_0;
                    nxt_serve_dir = 1'b1;
                    if (inc_0 == WIN) begin
                        nxt_winner = 2'b01;
                        nxt_state  = ST_OVER;
                    end else begin
                        nxt_state = ST_SERVE_WAIT;
                        clr_wait  = 1'b1;
                    end
                end else if (score_valid && who_scored == 2'b10) begin
                    nxt_num_1     = inc_1;
                    nxt_serve_dir = 1'b0;
                    if (inc_1 == WIN) begin
                        nxt_winner = 2'b10;
                        nxt_state  = ST_OVER;
                    end else begin
                        nxt_state = ST_SERVE_WAIT;
                        clr_wait  = 1'b1;
                    end
                end
            end
            default: nxt_state = ST_IDLE;
        endcase
    end

    // State and output registers. Reset clears everything immediately, so a pending serve is lost.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cur_state <= ST_IDLE;
            num_0     <= 4'd0;
            num_1     <= 4'd0;
            winner    <= 2'b00;
            serve     <= 1'b0;
            serve_dir <= 1'b0;
        end else begin
            cur_state <= nxt_state;
            num_0     <= nxt_num_0;
            num_1     <= nxt_num_1;
            winner    <= nxt_winner;
            serve     <= nxt_serve;
            serve_dir <= nxt_serve_dir;
        end
    end

endmodule
